// File: rtl/if_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_stage : PC, single-outstanding imem fetch, one-word stall buffer, IF/ID
// Revision : 1.0
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        hold_vld_q, hold_vld_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic        id_vld_q, id_vld_d;

   logic        w_grant;
   logic        w_resp;

   // A new fetch may go out in the same cycle the previous one returns,
   // but only if that word is consumed straight into IF/ID.
   assign imem_req  = !reset && !redirect_valid && !hold_vld_q &&
                      ((state_q == S_RUN) ||
                       ((state_q == S_WAIT) && imem_rvalid && !stall));
   assign imem_addr = pc_q;
   assign w_grant   = imem_req && imem_gnt;
   assign w_resp    = (state_q == S_WAIT) && imem_rvalid;

   assign if_id_inst  = id_inst_q;
   assign if_id_pc    = id_pc_q;
   assign if_id_pc4   = id_pc4_q;
   assign if_id_valid = id_vld_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      hold_vld_d  = hold_vld_q;
      hold_inst_d = hold_inst_q;
      hold_pc_d   = hold_pc_q;
      id_inst_d   = id_inst_q;
      id_pc_d     = id_pc_q;
      id_pc4_d    = id_pc4_q;
      id_vld_d    = id_vld_q;

      if (redirect_valid) begin
         id_inst_d  = 32'h0;
         id_vld_d   = 1'b0;
         hold_vld_d = 1'b0;
         pc_d       = redirect_pc;
         // A fetch still in flight must have its response swallowed.
         case (state_q)
            S_WAIT:  state_d = imem_rvalid ? S_RUN : S_DROP;
            S_DROP:  state_d = imem_rvalid ? S_RUN : S_DROP;
            default: state_d = S_RUN;
         endcase
      end else begin
         if (w_grant) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
         end

         case (state_q)
            S_RUN:   if (w_grant) state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_d = w_grant ? S_WAIT : S_RUN;
            S_DROP:  if (imem_rvalid) state_d = S_RUN;
            default: state_d = S_RUN;
         endcase

         if (!stall) begin
            if (hold_vld_q) begin
               id_inst_d  = hold_inst_q;
               id_pc_d    = hold_pc_q;
               id_pc4_d   = hold_pc_q + 32'd4;
               id_vld_d   = 1'b1;
               hold_vld_d = 1'b0;
            end else if (w_resp) begin
               id_inst_d = imem_rdata;
               id_pc_d   = req_pc_q;
               id_pc4_d  = req_pc_q + 32'd4;
               id_vld_d  = 1'b1;
            end else begin
               id_inst_d = 32'h0;
               id_vld_d  = 1'b0;
            end
         end else if (w_resp) begin
            hold_vld_d  = 1'b1;
            hold_inst_d = imem_rdata;
            hold_pc_d   = req_pc_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_RUN;
         pc_q        <= RESET_PC;
         req_pc_q    <= 32'h0;
         hold_vld_q  <= 1'b0;
         hold_inst_q <= 32'h0;
         hold_pc_q   <= 32'h0;
         id_inst_q   <= 32'h0;
         id_pc_q     <= 32'h0;
         id_pc4_q    <= 32'h0;
         id_vld_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         hold_vld_q  <= hold_vld_d;
         hold_inst_q <= hold_inst_d;
         hold_pc_q   <= hold_pc_d;
         id_inst_q   <= id_inst_d;
         id_pc_q     <= id_pc_d;
         id_pc4_q    <= id_pc4_d;
         id_vld_q    <= id_vld_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_if_stage : directed cycle-by-cycle checks of if_stage against a simple
//               grant/latency instruction memory returning ~addr as data.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;

   int          n_vec = 0;
   int          n_err = 0;

   int          lat;
   logic        flush;
   logic        mem_pend;
   logic [31:0] mem_addr;
   int          mem_cnt;
   logic        mem_rv;

   if_stage #(.RESET_PC(32'h0000_0100)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_id_inst     (if_id_inst),
      .if_id_pc       (if_id_pc),
      .if_id_pc4      (if_id_pc4),
      .if_id_valid    (if_id_valid)
   );

   always #5 clk = ~clk;

   // Memory: response 'lat' cycles after the grant, data = ~address.
   always @(posedge clk) begin
      if (flush) begin
         mem_pend <= 1'b0;
         mem_cnt  <= 0;
      end else begin
         if (mem_rv) mem_pend <= 1'b0;
         if (imem_req && imem_gnt) begin
            mem_pend <= 1'b1;
            mem_addr <= imem_addr;
            mem_cnt  <= lat - 1;
         end else if (mem_pend && mem_cnt > 0) begin
            mem_cnt <= mem_cnt - 1;
         end
      end
   end

   assign mem_rv      = mem_pend && (mem_cnt == 0);
   assign imem_rvalid = mem_rv;
   assign imem_rdata  = mem_rv ? ~mem_addr : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_if(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic v);
      chk({tag, ".inst"},  if_id_inst, inst);
      chk({tag, ".pc"},    if_id_pc,   pc);
      chk({tag, ".pc4"},   if_id_pc4,  pc4);
      chk({tag, ".valid"}, 32'(if_id_valid), 32'(v));
   endtask

   task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
      chk({tag, ".req"},  32'(imem_req), 32'(r));
      chk({tag, ".addr"}, imem_addr, a);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; flush = 1'b1; imem_gnt = 1'b1; lat = 1; stall = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      step(); step(); #1;
      chk("rst.req", 32'(imem_req), 32'h0);
      chk_if("rst", 32'h0, 32'h0, 32'h0, 1'b0);

      // Zero-wait stream from RESET_PC
      step(); reset = 1'b0; flush = 1'b0; #1;
      chk_req("c0", 1'b1, 32'h100);
      step(); #1; chk_req("c1", 1'b1, 32'h104); chk("c1.valid", 32'(if_id_valid), 32'h0);
      step(); #1; chk_if("c2", ~32'h100, 32'h100, 32'h104, 1'b1);
      step(); #1; chk_if("c3", ~32'h104, 32'h104, 32'h108, 1'b1);
      step(); #1; chk_if("c4", ~32'h108, 32'h108, 32'h10C, 1'b1);

      // Four-cycle stall: 0x110 parks in the hold buffer
      for (int i = 0; i < 4; i++) begin
         step(); stall = 1'b1; #1;
         chk_if("stall", ~32'h10C, 32'h10C, 32'h110, 1'b1);
         chk("stall.req", 32'(imem_req), 32'h0);
      end
      step(); stall = 1'b0; #1;
      chk("rel.req", 32'(imem_req), 32'h0);
      chk_if("rel", ~32'h10C, 32'h10C, 32'h110, 1'b1);
      step(); #1; chk_if("r1", ~32'h110, 32'h110, 32'h114, 1'b1); chk_req("r1", 1'b1, 32'h114);
      step(); #1; chk_if("r2", 32'h0, 32'h110, 32'h114, 1'b0);
      step(); #1; chk_if("r3", ~32'h114, 32'h114, 32'h118, 1'b1);

      // Redirect while the slow fetch of 0x10C is outstanding
      step(); reset = 1'b1; flush = 1'b1;
      step();
      step(); reset = 1'b0; flush = 1'b0; #1; chk_req("d0", 1'b1, 32'h100);
      step(); #1; chk_req("d1", 1'b1, 32'h104);
      step(); #1; chk_if("d2", ~32'h100, 32'h100, 32'h104, 1'b1);
      step(); lat = 4; #1; chk_if("d3", ~32'h104, 32'h104, 32'h108, 1'b1);
      step(); redirect_valid = 1'b1; redirect_pc = 32'h200; lat = 1; #1;
      chk_req("d4", 1'b0, 32'h110);
      chk_if("d4", ~32'h108, 32'h108, 32'h10C, 1'b1);
      step(); redirect_valid = 1'b0; #1;
      chk_req("d5", 1'b0, 32'h200); chk_if("d5", 32'h0, 32'h108, 32'h10C, 1'b0);
      step(); #1; chk_req("d6", 1'b0, 32'h200); chk_if("d6", 32'h0, 32'h108, 32'h10C, 1'b0);
      step(); #1; chk_req("d7", 1'b0, 32'h200);
      step(); #1; chk_req("d8", 1'b1, 32'h200); chk("d8.valid", 32'(if_id_valid), 32'h0);
      step(); #1; chk_if("d9", 32'h0, 32'h108, 32'h10C, 1'b0);
      step(); #1; chk_if("d10", ~32'h200, 32'h200, 32'h204, 1'b1);

      // Redirect coincident with a response under stall
      step(); stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
      chk_req("d11", 1'b0, 32'h20C);
      chk_if("d11", ~32'h204, 32'h204, 32'h208, 1'b1);
      step(); redirect_valid = 1'b0; #1;
      chk_req("d12", 1'b1, 32'h300); chk_if("d12", 32'h0, 32'h204, 32'h208, 1'b0);
      step(); stall = 1'b0; #1;
      chk_req("d13", 1'b1, 32'h304); chk_if("d13", 32'h0, 32'h204, 32'h208, 1'b0);

      // Grant withheld for five cycles
      step(); imem_gnt = 1'b0; #1;
      chk_if("d14", ~32'h300, 32'h300, 32'h304, 1'b1); chk_req("d14", 1'b1, 32'h308);
      step(); #1; chk_req("d15", 1'b1, 32'h308); chk_if("d15", ~32'h304, 32'h304, 32'h308, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         chk_req("nognt", 1'b1, 32'h308);
         chk_if("nognt", 32'h0, 32'h304, 32'h308, 1'b0);
      end
      step(); imem_gnt = 1'b1; #1; chk_req("d19", 1'b1, 32'h308);
      step(); #1; chk_req("d20", 1'b1, 32'h30C); chk_if("d20", 32'h0, 32'h304, 32'h308, 1'b0);

      // PC wrap at the top of the address space
      step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
      chk_if("d21", ~32'h308, 32'h308, 32'h30C, 1'b1); chk("d21.req", 32'(imem_req), 32'h0);
      step(); redirect_valid = 1'b0; #1; chk_req("d22", 1'b1, 32'hFFFF_FFFC);
      step(); #1; chk_req("d23", 1'b1, 32'h0);
      step(); #1; chk_if("d24", 32'h3, 32'hFFFF_FFFC, 32'h0, 1'b1);
      step(); lat = 3; #1;
      chk_if("d25", 32'hFFFF_FFFF, 32'h0, 32'h4, 1'b1); chk_req("d25", 1'b1, 32'h8);

      // Reset with a fetch in flight; its late response must be ignored
      step(); reset = 1'b1; #1; chk("d26.req", 32'(imem_req), 32'h0);
      step(); reset = 1'b0; imem_gnt = 1'b0; lat = 1; #1;
      chk_if("d27", 32'h0, 32'h0, 32'h0, 1'b0); chk_req("d27", 1'b1, 32'h100);
      step(); #1; chk_req("d28", 1'b1, 32'h100); chk_if("d28", 32'h0, 32'h0, 32'h0, 1'b0);
      step(); imem_gnt = 1'b1; #1; chk_if("d29", 32'h0, 32'h0, 32'h0, 1'b0);
      step(); #1; chk("d30.valid", 32'(if_id_valid), 32'h0);
      step(); #1; chk_if("d31", ~32'h100, 32'h100, 32'h104, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
